// File: rtl/span_loader.sv
// Streams a 34-word parameter frame into the margin engine, waits for it to settle,
// reads back the initial margin and hands it off. Define SPAN_LOADER_POLL_EN to re-read until nonzero.
module span_loader #(
   parameter int SETTLE_CYCLES = 16,
   parameter int POLL_MAX      = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [5:0]  offset,
   output logic [15:0] writeData,
   output logic        write,
   output logic        read,
   output logic        chipselect,
   input  logic [15:0] readData,
   output logic [15:0] margin_data,
   output logic        margin_valid,
   input  logic        margin_ready,
   output logic        margin_timeout,
   output logic        busy
);

   typedef enum logic [2:0] {LOAD, SETTLE, READ, CAPTURE, OUT, CLEAR} state_t;

   localparam logic [5:0] LAST_WORD    = 6'd33;
   localparam logic [5:0] CLEAR_OFFSET = 6'd63;
   localparam logic [7:0] SETTLE_LIMIT = SETTLE_CYCLES[7:0];

   state_t      state_q, state_d;
   logic [5:0]  count_q, count_d;
   logic [7:0]  settle_q, settle_d;
   logic        ready_q, ready_d;
   logic        cs_q, cs_d;
   logic        wr_q, wr_d;
   logic        rd_q, rd_d;
   logic [5:0]  offset_q, offset_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] mdata_q, mdata_d;
   logic        mvalid_q, mvalid_d;
   logic        accept;

`ifdef SPAN_LOADER_POLL_EN
   localparam logic [7:0] POLL_LIMIT = POLL_MAX[7:0];
   logic [7:0] poll_q, poll_d;
   logic       tmo_q, tmo_d;
`endif

   assign accept = in_valid & ready_q;

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      settle_d = settle_q;
      cs_d     = 1'b0;
      wr_d     = 1'b0;
      rd_d     = 1'b0;
      offset_d = '0;
      wdata_d  = '0;
      mdata_d  = mdata_q;
`ifdef SPAN_LOADER_POLL_EN
      poll_d   = poll_q;
      tmo_d    = tmo_q;
`endif
      case (state_q)
         LOAD: begin
            if (accept) begin
               cs_d     = 1'b1;
               wr_d     = 1'b1;
               offset_d = count_q;
               wdata_d  = in_data;
               if (count_q == LAST_WORD) begin
                  count_d = '0;
                  state_d = SETTLE;
               end else begin
                  count_d = count_q + 6'd1;
               end
            end
         end
         SETTLE: begin
            // The cycle carrying the last write is counted as cycle 0 of the settle window.
            if (settle_q == SETTLE_LIMIT) begin
               settle_d = '0;
               state_d  = READ;
               cs_d     = 1'b1;
               rd_d     = 1'b1;
            end else begin
               settle_d = settle_q + 8'd1;
            end
         end
         READ: begin
            state_d = CAPTURE;
`ifdef SPAN_LOADER_POLL_EN
            poll_d  = poll_q + 8'd1;
`endif
         end
         CAPTURE: begin
            mdata_d = readData;
`ifdef SPAN_LOADER_POLL_EN
            if ((readData == 16'd0) && (poll_q < POLL_LIMIT)) begin
               state_d = READ;
               cs_d    = 1'b1;
               rd_d    = 1'b1;
            end else begin
               state_d = OUT;
               tmo_d   = (readData == 16'd0);
               poll_d  = '0;
            end
`else
            state_d = OUT;
`endif
         end
         OUT: begin
            if (margin_ready) begin
               state_d  = CLEAR;
               cs_d     = 1'b1;
               wr_d     = 1'b1;
               offset_d = CLEAR_OFFSET;
               wdata_d  = 16'd0;
`ifdef SPAN_LOADER_POLL_EN
               tmo_d    = 1'b0;
`endif
            end
         end
         CLEAR: begin
            state_d = LOAD;
         end
         default: begin
            state_d = LOAD;
         end
      endcase
      ready_d  = (state_d == LOAD);
      mvalid_d = (state_d == OUT);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= LOAD;
         count_q  <= '0;
         settle_q <= '0;
         ready_q  <= 1'b0;
         cs_q     <= 1'b0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         offset_q <= '0;
         wdata_q  <= '0;
         mdata_q  <= '0;
         mvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         settle_q <= settle_d;
         ready_q  <= ready_d;
         cs_q     <= cs_d;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         offset_q <= offset_d;
         wdata_q  <= wdata_d;
         mdata_q  <= mdata_d;
         mvalid_q <= mvalid_d;
      end
   end

`ifdef SPAN_LOADER_POLL_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         poll_q <= '0;
         tmo_q  <= 1'b0;
      end else begin
         poll_q <= poll_d;
         tmo_q  <= tmo_d;
      end
   end

   assign margin_timeout = tmo_q;
`else
   assign margin_timeout = 1'b0;
`endif

   assign in_ready     = ready_q;
   assign chipselect   = cs_q;
   assign write        = wr_q;
   assign read         = rd_q;
   assign offset       = offset_q;
   assign writeData    = wdata_q;
   assign margin_data  = mdata_q;
   assign margin_valid = mvalid_q;
   assign busy         = (state_q != LOAD) || (count_q != 6'd0);

endmodule

// File: doc/span_loader.md
SPAN_LOADER -- requirements
Module: span_loader

Interface
REQ-001 Parameter SETTLE_CYCLES, default 16, SHALL set idle cycles between the last parameter write and the first margin read (1..255).
REQ-002 Parameter POLL_MAX, default 255, SHALL set the maximum margin reads per frame when polling is compiled in (1..255).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_data  input  16  SHALL carry one frame word.
REQ-006 in_valid  input  1  SHALL mark in_data valid.
REQ-007 in_ready  output  1  SHALL signal that the loader accepts a word this cycle.
REQ-008 offset  output  6  SHALL be the register offset driven to the margin engine.
REQ-009 writeData  output  16  SHALL be the write data driven to the margin engine.
REQ-010 write, read, chipselect  output  1 each  SHALL be the margin-engine bus strobes.
REQ-011 readData  input  16  SHALL be the margin engine's registered read data.
REQ-012 margin_data  output  16  SHALL carry the captured initial margin.
REQ-013 margin_valid / margin_ready  output / input  1 each  SHALL form the result handshake.
REQ-014 margin_timeout  output  1  SHALL qualify margin_data as a poll timeout (held 0 without polling).
REQ-015 busy  output  1  SHALL be high whenever the state is not LOAD or word count is nonzero.

Function
REQ-016 A frame SHALL be exactly 34 words; word k (0..33) SHALL be written to offset k.
REQ-017 States SHALL be LOAD, SETTLE, READ, CAPTURE, OUT, CLEAR.
REQ-018 In LOAD in_ready SHALL be 1; in all other states 0.
REQ-019 A word SHALL be accepted when in_valid and in_ready are both 1; the next cycle SHALL drive chipselect=1, write=1, read=0, offset=k, writeData=word (1-cycle latency).
REQ-020 Strobes SHALL be registered and high for exactly one cycle per transaction; write and read SHALL never be high together.
REQ-021 The word count SHALL be 6 bits; acceptance of word 33 SHALL reset it to 0 and transition to SETTLE.
REQ-022 in_valid low mid-frame SHALL stall without losing the count or issuing a write.
REQ-023 SETTLE SHALL count SETTLE_CYCLES cycles, then transition to READ.
REQ-024 READ SHALL drive chipselect=1, read=1, offset=0 for one cycle, then transition to CAPTURE.
REQ-025 CAPTURE SHALL sample readData into margin_data and transition to OUT (or back to READ per REQ-034).
REQ-026 OUT SHALL hold margin_valid=1 and margin_data stable until margin_ready=1, then transition to CLEAR.
REQ-027 CLEAR SHALL issue one write to offset 63 with writeData=0, clearing the engine's start strobes, then return to LOAD.
REQ-028 margin_valid SHALL drop in the cycle after the handshake; margin_ready while margin_valid=0 SHALL be ignored.

Reset
REQ-029 Reset low SHALL immediately force state LOAD, word count 0, settle/poll counters 0.
REQ-030 Reset SHALL force every output to 0 except in_ready, which SHALL be 1 after reset release.
REQ-031 Reset mid-frame SHALL discard the partial frame; the next accepted word SHALL be word 0.

Configuration
REQ-032 Macro SPAN_LOADER_POLL_EN SHALL compile in margin polling.
REQ-033 Without SPAN_LOADER_POLL_EN, CAPTURE SHALL always transition to OUT after one read, and margin_timeout SHALL be 0.
REQ-034 With SPAN_LOADER_POLL_EN, CAPTURE SHALL return to READ when readData is 0 and fewer than POLL_MAX reads have occurred; otherwise go to OUT.
REQ-035 With SPAN_LOADER_POLL_EN, margin_timeout SHALL be 1 with margin_valid when POLL_MAX reads all returned 0.

Verification
REQ-036 34 back-to-back words 0x0100+k -> 34 single-cycle writes, offset k, writeData 0x0100+k, one cycle after each accept.
REQ-037 in_valid deasserted for 5 cycles after word 10 -> no strobes during gap; word 11 lands at offset 11.
REQ-038 Full frame, SETTLE_CYCLES=16, readData=0x1234 -> read exactly 17 cycles after the write of offset 33; margin_data=0x1234 with margin_valid.
REQ-039 margin_ready held 0 for 8 cycles -> margin_valid and margin_data stable 8 cycles; after handshake one write to offset 63 with data 0, then in_ready=1.
REQ-040 Polling on, POLL_MAX=4, readData stuck at 0 -> exactly 4 reads, margin_valid=1, margin_timeout=1, margin_data=0.
REQ-041 Reset asserted after word 20 -> all strobes 0 at once; after release the next word is written to offset 0.
